// File: rtl/dlf16_pkg.sv
// DLFloat16 shared definitions.
// Format is {sign, exp[5:0], mant[8:0]}: biased exponent, hidden leading one,
// no subnormals. The all-zero word encodes zero.
package dlf16_pkg;

    localparam int EXP_W  = 6;
    localparam int MANT_W = 9;
    localparam int FLT_W  = 1 + EXP_W + MANT_W;

    localparam logic [EXP_W-1:0] EXP_BIAS   = 6'd31;
    localparam logic [FLT_W-1:0] DLF16_ZERO = '0;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } dlf16_t;

    // Magnitude of a signed 32-bit value, computed one bit wider so that
    // -2^31 yields +2^31 instead of wrapping back to a negative number.
    function automatic logic [32:0] abs33(input logic [31:0] x);
        logic [32:0] wide;
        wide = {x[31], x};
        return x[31] ? (33'd0 - wide) : wide;
    endfunction

endpackage

// File: rtl/dlf16_i2f_core.sv
// Combinational unsigned-magnitude to DLFloat16 converter.
// Finds the leading one, normalizes it to the hidden-bit position, keeps the
// next MANT_W bits (truncated, no rounding) and packs sign/exponent/mantissa.
//   sign   : sign to apply to a nonzero result
//   mag    : |x|, 0 .. 2^31
//   result : packed DLFloat16; zero magnitude gives the zero encoding
module dlf16_i2f_core
    import dlf16_pkg::*;
(
    input  logic        sign,
    input  logic [31:0] mag,
    output dlf16_t      result
);

    logic [4:0]  lead;
    logic [31:0] norm;
    logic [22:0] norm_unused;

    // NOTE: every variable gets a default at the top of the always_comb so no
    // path leaves one unassigned; that is what keeps it from becoming a latch.
    always_comb begin
        lead   = '0;
        norm   = '0;
        result = DLF16_ZERO;
        // Last match wins, so lead ends on the most significant set bit.
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                lead = 5'(i);
            end
        end
        // Move the leading one to bit 31; the mantissa sits right below it.
        norm = mag << (5'd31 - lead);
        if (mag != '0) begin
            result.sign = sign;
            result.exp  = {1'b0, lead} + EXP_BIAS;
            result.mant = norm[30 -: MANT_W];
        end
    end

    // Hidden bit and truncated tail are dropped on purpose.
    assign norm_unused = {norm[31], norm[21:0]};

endmodule

// File: rtl/fp_cvt_sched.sv
// Two-requester int32 -> DLFloat16 converter with one shared pipeline.
// Round-robin arbitration feeds S1 (sign, |x|, src, tag); the combinational
// converter sits between S1 and S2; S2 is the output register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in0_*/in1_*           : valid/ready operand ports with opaque tag
//   out_valid/out_ready   : result handshake
//   out_float             : DLFloat16 result {sign, exp[5:0], mant[8:0]}
//   out_src / out_tag     : originating requester and its tag
//   conv_count            : completed output handshakes, wraps at 16 bits
module fp_cvt_sched
    import dlf16_pkg::*;
#(
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [31:0]      in0_int,
    input  logic [TAG_W-1:0] in0_tag,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [31:0]      in1_int,
    input  logic [TAG_W-1:0] in1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_float,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      conv_count
);

    // Requester granted last on an accepted transfer; 1 so requester 0 wins
    // the first tie after reset.
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             s2_adv;
    logic             s1_load;

    logic             s1_valid;
    logic             s1_sign;
    logic [31:0]      s1_mag;
    logic             s1_src;
    logic [TAG_W-1:0] s1_tag;

    logic [31:0]      sel_int;
    logic [TAG_W-1:0] sel_tag;
    logic [32:0]      sel_mag;
    logic             sel_mag_unused;
    dlf16_t           conv_result;

    always_comb begin
        grant0 = in0_valid && (!in1_valid || last_grant);
        grant1 = in1_valid && (!in0_valid || !last_grant);
    end

    assign s2_adv  = !out_valid || out_ready;
    assign s1_load = !s1_valid || s2_adv;

    // Gated by rst_n so both readies drop the moment reset asserts.
    assign in0_ready = rst_n && grant0 && s1_load;
    assign in1_ready = rst_n && grant1 && s1_load;

    assign sel_int = in1_ready ? in1_int : in0_int;
    assign sel_tag = in1_ready ? in1_tag : in0_tag;
    assign sel_mag = abs33(sel_int);
    // |x| never exceeds 2^31, so the extra magnitude bit is always zero.
    assign sel_mag_unused = sel_mag[32];

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            s1_valid   <= 1'b0;
        end else begin
            if (in0_ready) begin
                last_grant <= 1'b0;
            end else if (in1_ready) begin
                last_grant <= 1'b1;
            end
            if (s1_load) begin
                s1_valid <= in0_ready || in1_ready;
            end
        end
    end

    // NOTE: the S1 payload has no reset; it is only consumed while s1_valid
    // is set, and s1_valid is reset.
    always_ff @(posedge clk) begin
        if (s1_load && (in0_ready || in1_ready)) begin
            s1_sign <= sel_int[31];
            s1_mag  <= sel_mag[31:0];
            s1_src  <= in1_ready;
            s1_tag  <= sel_tag;
        end
    end

    dlf16_i2f_core u_core (
        .sign   (s1_sign),
        .mag    (s1_mag),
        .result (conv_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_float <= '0;
            out_src   <= 1'b0;
            out_tag   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_float <= conv_result;
                out_src   <= s1_src;
                out_tag   <= s1_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_count <= '0;
        end else if (out_valid && out_ready) begin
            conv_count <= conv_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fp_cvt_sched.sv
// Directed bench for fp_cvt_sched: hand-computed DLFloat16 values, a small
// two-slot transaction model for timing/ordering, and reset/stall/wrap cases.
module tb_fp_cvt_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in0_valid, in1_valid, out_ready;
    logic        in0_ready, in1_ready;
    logic [31:0] in0_int, in1_int;
    logic [1:0]  in0_tag, in1_tag;
    logic        out_valid, out_src;
    logic [15:0] out_float, conv_count;
    logic [1:0]  out_tag;

    int checks = 0;
    int failures = 0;

    fp_cvt_sched #(.TAG_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in0_int    (in0_int),
        .in0_tag    (in0_tag),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .in1_int    (in1_int),
        .in1_tag    (in1_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_float  (out_float),
        .out_src    (out_src),
        .out_tag    (out_tag),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    // Per-requester operand lists with their hand-computed results.
    logic [31:0] l0_int [8];
    logic [1:0]  l0_tag [8];
    logic [15:0] l0_flt [8];
    logic [31:0] l1_int [8];
    logic [1:0]  l1_tag [8];
    logic [15:0] l1_flt [8];
    int n0, n1, i0, i1;

    // Expected pipeline contents: S1 and S2 slots.
    typedef struct packed {
        logic        src;
        logic [1:0]  tag;
        logic [15:0] flt;
    } res_t;
    res_t        m1, m2;
    logic        m1v, m2v, lg;
    logic [15:0] exp_cnt;
    int          glog [16];
    int          gn;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic set0(input int k, input logic [31:0] v, input logic [1:0] t, input logic [15:0] f);
        l0_int[k] = v; l0_tag[k] = t; l0_flt[k] = f;
    endtask

    task automatic set1(input int k, input logic [31:0] v, input logic [1:0] t, input logic [15:0] f);
        l1_int[k] = v; l1_tag[k] = t; l1_flt[k] = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; asserts reset with both valids high, checks the
    // cleared state immediately, then releases reset mid-cycle.
    task automatic apply_reset();
        rst_n = 1'b0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_float", out_float, 0);
        check("rst_out_src", out_src, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_conv_count", conv_count, 0);
        check("rst_in0_ready", in0_ready, 0);
        check("rst_in1_ready", in1_ready, 0);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m1v = 1'b0; m2v = 1'b0; lg = 1'b1; exp_cnt = '0;
        i0 = 0; i1 = 0; gn = 0;
    endtask

    // One clock cycle: drive, check readies and outputs against the model,
    // advance the model as the edge would, then take the edge.
    task automatic cycle(input logic en0, input logic en1, input logic rdy);
        logic v0, v1, g0, g1, adv2, load1, er0, er1;
        v0 = en0 && (i0 < n0);
        v1 = en1 && (i1 < n1);
        in0_valid = v0;
        in1_valid = v1;
        in0_int = 32'h0; in0_tag = 2'd0;
        in1_int = 32'h0; in1_tag = 2'd0;
        if (v0) begin in0_int = l0_int[i0]; in0_tag = l0_tag[i0]; end
        if (v1) begin in1_int = l1_int[i1]; in1_tag = l1_tag[i1]; end
        out_ready = rdy;
        #1;
        g0 = v0 && (!v1 || lg);
        g1 = v1 && (!v0 || !lg);
        adv2  = !m2v || rdy;
        load1 = !m1v || adv2;
        er0 = g0 && load1;
        er1 = g1 && load1;
        check("in0_ready", in0_ready, er0);
        check("in1_ready", in1_ready, er1);
        check("out_valid", out_valid, m2v);
        if (m2v) begin
            check("out_float", out_float, m2.flt);
            check("out_src", out_src, m2.src);
            check("out_tag", out_tag, m2.tag);
        end
        check("conv_count", conv_count, exp_cnt);
        if (gn < 16) begin
            if (in0_ready && in0_valid) begin glog[gn] = 0; gn++; end
            else if (in1_ready && in1_valid) begin glog[gn] = 1; gn++; end
        end
        if (m2v && rdy) exp_cnt = exp_cnt + 16'd1;
        if (adv2) begin m2v = m1v; m2 = m1; end
        if (load1) begin
            m1v = er0 || er1;
            if (er0) begin
                m1 = '{src: 1'b0, tag: l0_tag[i0], flt: l0_flt[i0]};
                lg = 1'b0; i0++;
            end else if (er1) begin
                m1 = '{src: 1'b1, tag: l1_tag[i1], flt: l1_flt[i1]};
                lg = 1'b1; i1++;
            end
        end
        tick();
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (i0 >= n0 && i1 >= n1 && !m1v && !m2v) break;
            cycle(1'b1, 1'b1, 1'b1);
        end
    endtask

    task automatic load_mixed();
        set0(0, 32'd1,          2'd0, 16'h3E00);
        set0(1, 32'd3,          2'd1, 16'h4100);
        set0(2, 32'hFFFF_FFFF,  2'd2, 16'hBE00);
        set0(3, 32'h8000_0000,  2'd3, 16'hFC00);
        set1(0, 32'hFFFF_FFFA,  2'd3, 16'hC300);
        set1(1, 32'd0,          2'd2, 16'h0000);
        set1(2, 32'h7FFF_FFFF,  2'd1, 16'h7BFF);
        set1(3, 32'd6,          2'd0, 16'h4300);
    endtask

    initial begin
        int acc;
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        in0_int = '0; in1_int = '0; in0_tag = '0; in1_tag = '0;
        n0 = 0; n1 = 0;
        tick();
        apply_reset();

        // Single requester 0, back-to-back small values.
        set0(0, 32'd0,         2'd0, 16'h0000);
        set0(1, 32'd1,         2'd1, 16'h3E00);
        set0(2, 32'd3,         2'd2, 16'h4100);
        set0(3, 32'hFFFF_FFFF, 2'd3, 16'hBE00);
        set0(4, 32'hFFFF_FFFA, 2'd0, 16'hC300);
        n0 = 5; n1 = 0; i0 = 0; i1 = 0;
        drain(20);
        check("count_single", conv_count, 5);

        // Extremes.
        set0(0, 32'h7FFF_FFFF, 2'd1, 16'h7BFF);
        set0(1, 32'h8000_0000, 2'd2, 16'hFC00);
        n0 = 2; i0 = 0;
        drain(20);
        check("count_extremes", conv_count, 7);

        // Both requesters continuously valid right after reset.
        apply_reset();
        load_mixed();
        n0 = 3; n1 = 3; i0 = 0; i1 = 0;
        drain(30);
        check("grant_0", glog[0], 0);
        check("grant_1", glog[1], 1);
        check("grant_2", glog[2], 0);
        check("grant_3", glog[3], 1);
        check("count_alternate", conv_count, 6);

        // Output stall for 5 cycles with the pipe full.
        load_mixed();
        n0 = 4; n1 = 4; i0 = 0; i1 = 0;
        repeat (2) cycle(1'b1, 1'b1, 1'b1);
        repeat (5) cycle(1'b1, 1'b1, 1'b0);
        drain(40);
        check("count_stall", conv_count, 14);

        // Reset with two operands in flight.
        load_mixed();
        n0 = 4; n1 = 4; i0 = 0; i1 = 0;
        repeat (2) cycle(1'b1, 1'b1, 1'b1);
        check("inflight_out_valid", out_valid, 1);
        apply_reset();
        n0 = 0; n1 = 0;
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        load_mixed();
        n0 = 2; n1 = 0;
        drain(20);
        check("count_after_reset", conv_count, 2);

        // Counter wrap: 65535 conversions, then one more.
        apply_reset();
        in1_valid = 1'b0;
        out_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 70000 && acc < 65535; c++) begin
            in0_valid = 1'b1;
            in0_int = c;
            #1;
            if (in0_ready) acc++;
            tick();
        end
        in0_valid = 1'b0;
        repeat (3) tick();
        check("wrap_accepts", acc, 65535);
        check("count_ffff", conv_count, 16'hFFFF);
        in0_valid = 1'b1;
        in0_int = 32'd1;
        #1;
        check("wrap_last_ready", in0_ready, 1);
        tick();
        in0_valid = 1'b0;
        repeat (3) tick();
        check("count_wrap", conv_count, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_cvt_sched.md
FP_CVT_SCHED -- requirements
Module: fp_cvt_sched

Interface
REQ-001 SHALL have parameter TAG_W, default 2, requester-supplied tag width returned with each result.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports in0_valid/in1_valid  input  1  requester 0/1 offers an operand.
REQ-005 SHALL have ports in0_ready/in1_ready  output  1  requester 0/1 operand accepted this cycle (valid&ready).
REQ-006 SHALL have ports in0_int/in1_int  input  32  signed two's-complement operand.
REQ-007 SHALL have ports in0_tag/in1_tag  input  TAG_W  opaque tag.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result (out_valid&out_ready).
REQ-010 SHALL have port out_float  output  16  DLFloat16 result {sign, exp[5:0], mant[8:0]}.
REQ-011 SHALL have port out_src  output  1  index of originating requester.
REQ-012 SHALL have port out_tag  output  TAG_W  tag of originating operand.
REQ-013 SHALL have port conv_count  output  16  number of completed output handshakes.

Function
REQ-014 SHALL share one int-to-DLFloat16 conversion pipeline between the two requesters.
REQ-015 SHALL arbitrate round-robin: one requester valid -> it wins; both valid -> the one not granted last wins; last-grant pointer resets to 1 so requester 0 wins first tie.
REQ-016 SHALL assert at most one inX_ready per cycle; inX_ready = granted(X) AND stage1 can load; ready may depend combinationally on both valids.
REQ-017 SHALL update last-grant pointer only on an accepted transfer.
REQ-018 SHALL use two register stages: S1 (operand, sign, |x|, src, tag), S2 = output registers (out_float/out_src/out_tag/out_valid).
REQ-019 SHALL advance S2 when !out_valid or out_ready; S1 when S1 empty or S2 advances; a stall freezes both stages with contents unchanged.
REQ-020 SHALL present result with out_valid high in the cycle after edge k+1 for an operand accepted at edge k when unstalled; sustained throughput 1 per cycle.
REQ-021 SHALL hold out_float/out_src/out_tag stable while out_valid & !out_ready.
REQ-022 SHALL convert: 0 -> 0x0000; else sign = bit31, e = index of leading one of |x| (0..31), exp = e+31, mant = the 9 bits below the leading one, left-justified, zero-filled, lower bits truncated (no rounding).
REQ-023 SHALL compute |x| in 33-bit-safe arithmetic so -2^31 -> 0xFC00.
REQ-024 SHALL increment conv_count on each output handshake, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL preserve per-requester order; results of different requesters leave in acceptance order.

Reset
REQ-026 SHALL on rst_n low immediately clear S1/S2 valid, out_valid=0, out_float=0, out_src=0, out_tag=0, conv_count=0, in0_ready=in1_ready=0, last-grant=1.
REQ-027 SHALL discard in-flight operands on reset mid-operation; no result for them ever appears.
REQ-028 SHALL accept the first operand no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place DLFloat16 field widths (EXP_W=6, MANT_W=9), EXP_BIAS=31 and the zero encoding in shared package dlf16_pkg.
REQ-030 SHALL implement conversion (leading-one detect, normalize, pack) in sub-module dlf16_i2f_core, combinational, instanced between S1 and S2.

Verification
REQ-031 SHALL test single requester 0: ints 0,1,3,-1,-6 back-to-back -> out_float 0x0000,0x3E00,0x4100,0xBE00,0xC300, one per cycle, latency per REQ-020.
REQ-032 SHALL test extremes: 0x7FFFFFFF -> 0x7BFF; 0x80000000 -> 0xFC00.
REQ-033 SHALL test both requesters continuously valid after reset -> grants alternate 0,1,0,1; out_src matches; tags returned intact.
REQ-034 SHALL test out_ready low 5 cycles with pipe full -> outputs frozen, both inX_ready low, no loss or duplication after release.
REQ-035 SHALL test rst_n pulsed low mid-stream with 2 operands in flight -> out_valid drops at once, conv_count=0, no stale result after release.
REQ-036 SHALL test 65536 conversions -> conv_count wraps to 0x0000.
